// File: rtl/alu_pkg.sv
// Shared definitions for the sequential calculator ALU: opcodes, FSM states,
// iteration-step modes and the iteration counter sizing helper.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_BOOTH = 1'b0,
    MODE_DIV   = 1'b1
  } iter_mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Counter must be able to hold WIDTH itself.
  function automatic int cnt_width(input int width);
    return clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation request / result bundle between the operand registers and the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 4
);
  logic                   start;
  logic [3:0]             op;
  logic [WIDTH-1:0]       data1;
  logic [WIDTH-1:0]       data2;
  logic [2*WIDTH-1:0]     result;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (output start, op, data1, data2, input result, busy, done, err);
  modport slave  (input start, op, data1, data2, output result, busy, done, err);
endinterface

// File: rtl/alu_seq_iter.sv
// One combinational iteration of either Booth radix-2 multiply (add/sub then
// arithmetic right shift) or restoring divide (shift left, trial subtract).
module alu_seq_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  iter_mode_e       mode,
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             qm1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             qm1_next
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] r_sh_s;
  logic [WIDTH:0] trial_s;

  // Single step for the selected algorithm.
  always_comb begin
    sum_s    = a;
    r_sh_s   = {a[WIDTH-1:0], q[WIDTH-1]};
    trial_s  = r_sh_s - m;
    a_next   = a;
    q_next   = q;
    qm1_next = qm1;
    case (mode)
      MODE_BOOTH: begin
        case ({q[0], qm1})
          2'b01:   sum_s = a + m;
          2'b10:   sum_s = a - m;
          default: sum_s = a;
        endcase
        {a_next, q_next, qm1_next} = {sum_s[WIDTH], sum_s, q};
      end
      MODE_DIV: begin
        // Sign bit of the trial difference decides keep vs restore.
        if (trial_s[WIDTH] == 1'b0) begin
          a_next = trial_s;
          q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
          a_next = r_sh_s;
          q_next = {q[WIDTH-2:0], 1'b0};
        end
        qm1_next = 1'b0;
      end
      default: begin
        a_next   = a;
        q_next   = q;
        qm1_next = qm1;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle integer ALU: add/sub in one pass, Booth multiply and restoring
// divide iterated WIDTH times through alu_seq_iter; start/busy/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_e               state_r, state_n;
  logic [CW-1:0]        cnt_r;
  logic [3:0]           op_r;
  logic [WIDTH-1:0]     d1_r, d2_r;
  logic [WIDTH:0]       a_r, m_r;
  logic [WIDTH-1:0]     q_r;
  logic                 qm1_r;
  logic [2*WIDTH-1:0]   result_r;
  logic                 busy_r, done_r, err_r;

  iter_mode_e           mode_s;
  logic [WIDTH:0]       a_s;
  logic [WIDTH-1:0]     q_s;
  logic                 qm1_s;
  logic                 long_op_s;
  logic [WIDTH:0]       addsub_s;
  logic [2*WIDTH-1:0]   fin_result_s;
  logic                 fin_err_s;

  assign mode_s    = (op_r == OP_MUL) ? MODE_BOOTH : MODE_DIV;
  assign long_op_s = (bus.op == OP_MUL) ||
                     ((bus.op == OP_DIV) && (bus.data2 != {WIDTH{1'b0}}));

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .mode     (mode_s),
    .a        (a_r),
    .q        (q_r),
    .qm1      (qm1_r),
    .m        (m_r),
    .a_next   (a_s),
    .q_next   (q_s),
    .qm1_next (qm1_s)
  );

  // Next-state sequencing.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_n = long_op_s ? ST_LOAD : ST_FIN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: state_n = ST_ITER;
      ST_ITER: begin
        if (cnt_r == CNT_LAST) begin
          state_n = ST_FIN;
        end else begin
          state_n = ST_ITER;
        end
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Final result selection from latched operands or iteration registers.
  always_comb begin
    fin_result_s = {(2*WIDTH){1'b0}};
    fin_err_s    = 1'b0;
    if (op_r == OP_SUB) begin
      addsub_s = {d1_r[WIDTH-1], d1_r} - {d2_r[WIDTH-1], d2_r};
    end else begin
      addsub_s = {d1_r[WIDTH-1], d1_r} + {d2_r[WIDTH-1], d2_r};
    end
    case (op_r)
      OP_ADD, OP_SUB: fin_result_s = {{(WIDTH-1){addsub_s[WIDTH]}}, addsub_s};
      OP_MUL:         fin_result_s = {a_r[WIDTH-1:0], q_r};
      OP_DIV: begin
        if (d2_r == {WIDTH{1'b0}}) begin
          fin_result_s = {d1_r, {WIDTH{1'b1}}};
          fin_err_s    = 1'b1;
        end else begin
          fin_result_s = {a_r[WIDTH-1:0], q_r};
          fin_err_s    = 1'b0;
        end
      end
      default: begin
        fin_result_s = {(2*WIDTH){1'b0}};
        fin_err_s    = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CW{1'b0}};
      op_r     <= 4'b0000;
      d1_r     <= {WIDTH{1'b0}};
      d2_r     <= {WIDTH{1'b0}};
      a_r      <= {(WIDTH+1){1'b0}};
      m_r      <= {(WIDTH+1){1'b0}};
      q_r      <= {WIDTH{1'b0}};
      qm1_r    <= 1'b0;
      result_r <= {(2*WIDTH){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n != ST_IDLE);
      done_r  <= (state_r == ST_FIN);
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            op_r  <= bus.op;
            d1_r  <= bus.data1;
            d2_r  <= bus.data2;
            err_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          // Multiplier/dividend go to Q; M is sign- or zero-extended.
          a_r   <= {(WIDTH+1){1'b0}};
          qm1_r <= 1'b0;
          cnt_r <= {CW{1'b0}};
          q_r   <= (op_r == OP_MUL) ? d2_r : d1_r;
          m_r   <= (op_r == OP_MUL) ? {d1_r[WIDTH-1], d1_r} : {1'b0, d2_r};
        end
        ST_ITER: begin
          a_r   <= a_s;
          q_r   <= q_s;
          qm1_r <= qm1_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        ST_FIN: begin
          result_r <= fin_result_s;
          err_r    <= fin_err_s;
          cnt_r    <= {CW{1'b0}};
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.result = result_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.err    = err_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: cycle-level behavioural model compared on
// every falling edge, directed literal cases, and an exhaustive/random sweep.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model state
  logic          exp_busy, exp_done, exp_err;
  logic [RW-1:0] exp_result;
  logic [RW-1:0] pend_r;
  logic          pend_e;
  int            remaining;
  logic          prev_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: result, err and edges from accept to done.
  function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [RW-1:0] r,
                                 output logic e, output int lat);
    int sa, sb, v;
    sa  = $signed(a);
    sb  = $signed(b);
    v   = 0;
    e   = 1'b0;
    lat = 1;
    case (op)
      OP_ADD: v = sa + sb;
      OP_SUB: v = sa - sb;
      OP_MUL: begin v = sa * sb; lat = W + 2; end
      OP_DIV: begin
        if (b == 0) begin
          v = (int'(a) << W) | ((1 << W) - 1);
          e = 1'b1;
        end else begin
          v = (int'(a % b) << W) | int'(a / b);
          lat = W + 2;
        end
      end
      default: begin v = 0; e = 1'b1; end
    endcase
    r = v[RW-1:0];
  endfunction

  // Behavioural model advanced on every rising edge.
  initial begin
    exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_result = '0; pend_r = '0; pend_e = 1'b0; remaining = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        exp_result = '0; remaining = 0;
      end else begin
        prev_busy = exp_busy;
        exp_done  = 1'b0;
        if (remaining > 0) begin
          remaining--;
          if (remaining == 0) begin
            exp_done   = 1'b1;
            exp_busy   = 1'b0;
            exp_result = pend_r;
            exp_err    = pend_e;
          end
        end
        if (!prev_busy && bus.start) begin
          ref_op(bus.op, bus.data1, bus.data2, pend_r, pend_e, remaining);
          exp_busy = 1'b1;
          exp_err  = 1'b0;
        end
      end
    end
  end

  // Compare DUT against model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy",   bus.busy,   exp_busy);
        check("done",   bus.done,   exp_done);
        check("result", bus.result, exp_result);
        check("err",    bus.err,    exp_err);
      end
    end
  end

  task automatic wait_done(input string name, output bit seen);
    int n;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
    end
    check({name, "_seen"}, seen, 1'b1);
  endtask

  // Issue one op from idle at a falling edge; checks latency and literal result.
  task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [RW-1:0] er, input logic ee,
                       input int elat);
    int n;
    bit seen;
    bus.start = 1'b1; bus.op = op; bus.data1 = a; bus.data2 = b;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    check({name, "_seen"}, seen, 1'b1);
    if (seen) begin
      check({name, "_lat"},    n,          elat);
      check({name, "_result"}, bus.result, er);
      check({name, "_err"},    bus.err,    ee);
      check({name, "_model"},  exp_result, er);
    end
  endtask

  task automatic sweep_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit seen;
    bus.start = 1'b1; bus.op = op; bus.data1 = a; bus.data2 = b;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("sweep", seen);
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 4'b0000; bus.data1 = '0; bus.data2 = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy",   bus.busy,   1'b0);
    check("rst_done",   bus.done,   1'b0);
    check("rst_result", bus.result, 8'h00);
    check("rst_err",    bus.err,    1'b0);
    rst = 1'b0;

    do_op("add_7_7",   OP_ADD,  4'd7,  4'd7,  8'h0E, 1'b0, 2);
    do_op("sub_3_5",   OP_SUB,  4'd3,  4'd5,  8'hFE, 1'b0, 2);
    do_op("mul_m8_m8", OP_MUL,  4'h8,  4'h8,  8'h40, 1'b0, W + 3);
    do_op("mul_7_m3",  OP_MUL,  4'h7,  4'hD,  8'hEB, 1'b0, W + 3);
    do_op("div_13_4",  OP_DIV,  4'd13, 4'd4,  8'h13, 1'b0, W + 3);
    do_op("div_15_1",  OP_DIV,  4'd15, 4'd1,  8'h0F, 1'b0, W + 3);
    do_op("div_9_0",   OP_DIV,  4'd9,  4'd0,  8'h9F, 1'b1, 2);
    do_op("illegal",   4'b0110, 4'd5,  4'd3,  8'h00, 1'b1, 2);

    // start held while busy with changed operands, then accepted in done cycle
    bus.start = 1'b1; bus.op = OP_MUL; bus.data1 = 4'd2; bus.data2 = 4'd3;
    @(negedge clk);
    bus.op = OP_ADD; bus.data1 = 4'd1; bus.data2 = 4'd1;
    wait_done("hs_first", seen);
    check("hs_first_result", bus.result, 8'h06);
    @(negedge clk);
    check("hs_b2b_busy", bus.busy, 1'b1);
    bus.start = 1'b0;
    wait_done("hs_second", seen);
    check("hs_second_result", bus.result, 8'h02);

    // reset during the third ITER cycle of a multiply
    bus.start = 1'b1; bus.op = OP_MUL; bus.data1 = 4'd5; bus.data2 = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",   bus.busy,   1'b0);
    check("mid_rst_result", bus.result, 8'h00);
    check("mid_rst_done",   bus.done,   1'b0);
    rst = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", bus.done, 1'b0);
    end
    do_op("post_rst_add", OP_ADD, 4'd1, 4'd1, 8'h02, 1'b0, 2);

    // exhaustive operand sweep of all legal ops
    for (int k = 0; k < 4; k++) begin
      for (int a = 0; a < (1 << W); a++) begin
        for (int b = 0; b < (1 << W); b++) begin
          if (n_errors < 20) sweep_op(4'b1000 >> k, W'(a), W'(b));
        end
      end
    end
    // random opcodes including illegal ones
    for (int i = 0; i < 80; i++) begin
      if (n_errors < 20) sweep_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
    end
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
